// File: rtl/rx_ipv4.sv
// Receive-side IPv4 header parser: validates the header, then forwards exactly the
// payload bytes one cycle after they arrive; pad/FCS is stripped, no backpressure.
module rx_ipv4 #(
   parameter int          OCT      = 8,
   parameter logic [3:0]  IPV4_VER = 4'd4,
   parameter logic [31:0] BCAST_IP = 32'hFFFFFFFF
) (
   input  logic            RX_CLK,
   input  logic            rst,
   input  logic [31:0]     ip_addr,
   input  logic            rx_ethernet_data_v,
   input  logic [OCT-1:0]  rx_ethernet_data,
   output logic            rx_ipv4_hdr_v,
   output logic [31:0]     rx_src_ip,
   output logic [7:0]      rx_protocol,
   output logic [15:0]     rx_ipv4_len,
   output logic            rx_ipv4_data_v,
   output logic [OCT-1:0]  rx_ipv4_data,
   output logic            rx_ipv4_done,
   output logic            rx_ipv4_err
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, WAIT_END, DROP} state_t;

   state_t          state;
   logic [5:0]      hcnt;
   logic [3:0]      ver;
   logic [3:0]      ihl;
   logic [OCT-1:0]  hi_byte;
   logic [15:0]     sum;
   logic [15:0]     total_len;
   logic [15:0]     frag;
   logic [7:0]      proto_r;
   logic [31:0]     src_r;
   logic [31:0]     dst_r;
   logic [15:0]     remaining;

   logic [16:0]     s17;
   logic [15:0]     sum_nxt;
   logic [15:0]     tl_n;
   logic [15:0]     frag_n;
   logic [7:0]      proto_n;
   logic [31:0]     src_n;
   logic [31:0]     dst_n;
   logic [15:0]     hdr_bytes;
   logic [5:0]      last_idx;
   logic            last_byte;
   logic            hdr_ok;

   // Field values including the byte being sampled now, so the decision on the
   // final header byte sees the complete header and checksum.
   always_comb begin
      s17       = {1'b0, sum} + {1'b0, hi_byte, rx_ethernet_data};
      sum_nxt   = s17[15:0] + {15'd0, s17[16]};
      tl_n      = total_len;
      frag_n    = frag;
      proto_n   = proto_r;
      src_n     = src_r;
      dst_n     = dst_r;
      case (hcnt)
         6'd2:  tl_n[15:8]    = rx_ethernet_data;
         6'd3:  tl_n[7:0]     = rx_ethernet_data;
         6'd6:  frag_n[15:8]  = rx_ethernet_data;
         6'd7:  frag_n[7:0]   = rx_ethernet_data;
         6'd9:  proto_n       = rx_ethernet_data;
         6'd12: src_n[31:24]  = rx_ethernet_data;
         6'd13: src_n[23:16]  = rx_ethernet_data;
         6'd14: src_n[15:8]   = rx_ethernet_data;
         6'd15: src_n[7:0]    = rx_ethernet_data;
         6'd16: dst_n[31:24]  = rx_ethernet_data;
         6'd17: dst_n[23:16]  = rx_ethernet_data;
         6'd18: dst_n[15:8]   = rx_ethernet_data;
         6'd19: dst_n[7:0]    = rx_ethernet_data;
         default: ;
      endcase
      hdr_bytes = {10'd0, ihl, 2'b00};
      last_idx  = {ihl, 2'b00} - 6'd1;
      last_byte = (hcnt == last_idx);
      hdr_ok    = (ver == IPV4_VER) && (ihl >= 4'd5) && (sum_nxt == 16'hFFFF) &&
                  (tl_n >= hdr_bytes) && ((dst_n == ip_addr) || (dst_n == BCAST_IP)) &&
                  !frag_n[13] && (frag_n[12:0] == 13'd0);
   end

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state          <= IDLE;
         hcnt           <= '0;
         ver            <= '0;
         ihl            <= '0;
         hi_byte        <= '0;
         sum            <= '0;
         total_len      <= '0;
         frag           <= '0;
         proto_r        <= '0;
         src_r          <= '0;
         dst_r          <= '0;
         remaining      <= '0;
         rx_ipv4_hdr_v  <= 1'b0;
         rx_src_ip      <= '0;
         rx_protocol    <= '0;
         rx_ipv4_len    <= '0;
         rx_ipv4_data_v <= 1'b0;
         rx_ipv4_data   <= '0;
         rx_ipv4_done   <= 1'b0;
         rx_ipv4_err    <= 1'b0;
      end else begin
         rx_ipv4_hdr_v  <= 1'b0;
         rx_ipv4_data_v <= 1'b0;
         rx_ipv4_done   <= 1'b0;
         rx_ipv4_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_ethernet_data_v) begin
                  ver     <= rx_ethernet_data[7:4];
                  ihl     <= rx_ethernet_data[3:0];
                  hi_byte <= rx_ethernet_data;
                  sum     <= '0;
                  hcnt    <= 6'd1;
                  state   <= HEADER;
               end
            end
            HEADER: begin
               if (!rx_ethernet_data_v) begin
                  rx_ipv4_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  hcnt      <= hcnt + 6'd1;
                  total_len <= tl_n;
                  frag      <= frag_n;
                  proto_r   <= proto_n;
                  src_r     <= src_n;
                  dst_r     <= dst_n;
                  if (!hcnt[0]) hi_byte <= rx_ethernet_data;
                  else          sum     <= sum_nxt;
                  if (last_byte) begin
                     if (hdr_ok) begin
                        rx_ipv4_hdr_v <= 1'b1;
                        rx_src_ip     <= src_n;
                        rx_protocol   <= proto_n;
                        rx_ipv4_len   <= tl_n - hdr_bytes;
                        remaining     <= tl_n - hdr_bytes;
                        state         <= (tl_n == hdr_bytes) ? WAIT_END : PAYLOAD;
                     end else begin
                        rx_ipv4_err <= 1'b1;
                        state       <= DROP;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (!rx_ethernet_data_v) begin
                  rx_ipv4_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  rx_ipv4_data   <= rx_ethernet_data;
                  rx_ipv4_data_v <= 1'b1;
                  remaining      <= remaining - 16'd1;
                  if (remaining == 16'd1) state <= WAIT_END;
               end
            end
            WAIT_END: begin
               if (!rx_ethernet_data_v) begin
                  rx_ipv4_done <= 1'b1;
                  state        <= IDLE;
               end
            end
            DROP: begin
               if (!rx_ethernet_data_v) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
